// File: rtl/mmc_bus_capture.sv
// mmc_bus_capture: MMC/eMMC bus sniffer. Oversamples the MMC pins, captures CMD/DAT on the
// selected CLK edge, buffers samples and serialises them as tagged bytes to an FX2 FIFO.
// Lost samples are reported in-band through marker records carrying a saturating drop count.
module mmc_bus_capture #(
  parameter int unsigned DAT_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BUF_DEPTH   = 16,
  parameter int unsigned ACT_W       = 24
) (
  input  logic                 FIFO_clk,
  input  logic                 reset_n,
  input  logic                 MMC_CLK,
  input  logic                 MMC_CMD,
  input  logic [DAT_WIDTH-1:0] MMC_DAT,
  input  logic                 cap_en,
  input  logic                 cfg_falling,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 active,
  output logic                 overflow
);

  localparam int unsigned PinW = DAT_WIDTH + 2;                         // {clk, cmd, dat}
  localparam int unsigned PayW = (DAT_WIDTH + 1 > 5) ? DAT_WIDTH + 1 : 5; // {cmd, dat} or count
  localparam int unsigned EntW = PayW + 1;                              // {kind, payload}
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ACT_W-1:0] ActLast = {{(ACT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StEmitLo, StEmitHi} state_e;

  // Synchroniser and history
  logic [SYNC_STAGES-1:0][PinW-1:0] sync_q, sync_d;
  logic [PinW-1:0]                  cur_q, cur_d, prev_q, prev_d;

  // Buffer
  logic [EntW-1:0] mem_q [BUF_DEPTH];
  logic [EntW-1:0] mem_d [BUF_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fifo_cnt_q, fifo_cnt_d;

  // Capture side
  logic [4:0]      drop_cnt_q, drop_cnt_d;
  logic            skid_vld_q, skid_vld_d;
  logic [EntW-1:0] skid_ent_q, skid_ent_d;

  // Serialiser / output register
  state_e      state_q, state_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [3:0]  hi_nib_q, hi_nib_d;

  // Activity
  logic             active_q, active_d;
  logic [ACT_W-1:0] act_cnt_q, act_cnt_d;

  // Combinational helpers
  logic            clk_cur, clk_prev, edge_det, new_smp, pin_chg;
  logic [EntW-1:0] smp_ent, push_ent, head;
  logic [7:0]      head_dat8;
  logic [CntW-1:0] occ;
  logic            out_free, release_w, slot_free, push, pop;

  assign clk_cur   = cur_q[PinW-1];
  assign clk_prev  = prev_q[PinW-1];
  assign edge_det  = cfg_falling ? (!clk_cur && clk_prev) : (clk_cur && !clk_prev);
  assign new_smp   = edge_det && cap_en;
  assign smp_ent   = {1'b0, PayW'(cur_q[DAT_WIDTH:0])};
  assign pin_chg   = (cur_q[PinW-2:0] != prev_q[PinW-2:0]);

  assign head      = mem_q[rd_ptr_q];
  assign head_dat8 = 8'(head[DAT_WIDTH-1:0]);
  assign out_free  = !out_valid_q || out_ready;
  // An entry keeps its buffer slot until its last byte has left the output register.
  assign occ       = fifo_cnt_q + CntW'(out_valid_q);
  assign release_w = out_valid_q && out_ready && out_last_q;
  assign slot_free = (occ < CntW'(BUF_DEPTH)) || release_w;

  // Pin synchroniser chain followed by cur/prev history
  always_comb begin
    sync_d[0] = {MMC_CLK, MMC_CMD, MMC_DAT};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    cur_d  = sync_q[SYNC_STAGES-1];
    prev_d = cur_q;
  end

  // Push arbitration: pending marker first, then skid entry or a fresh sample
  always_comb begin
    push       = 1'b0;
    push_ent   = '0;
    drop_cnt_d = drop_cnt_q;
    skid_vld_d = skid_vld_q;
    skid_ent_d = skid_ent_q;
    if (drop_cnt_q != 5'd0 && slot_free) begin
      push       = 1'b1;
      push_ent   = {1'b1, PayW'(drop_cnt_q)};
      drop_cnt_d = 5'd0;
      if (new_smp) begin
        skid_vld_d = 1'b1;
        skid_ent_d = smp_ent;
      end
    end else begin
      skid_vld_d = 1'b0;
      if (skid_vld_q || new_smp) begin
        if (slot_free) begin
          push     = 1'b1;
          push_ent = skid_vld_q ? skid_ent_q : smp_ent;
        end else if (drop_cnt_q != 5'd31) begin
          drop_cnt_d = drop_cnt_q + 5'd1;
        end
      end
    end
  end

  // Serialiser: turns buffer entries into tagged output bytes
  always_comb begin
    pop         = 1'b0;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    hi_nib_d    = hi_nib_q;
    unique case (state_q)
      StIdle, StEmitHi: begin
        if (out_free) begin
          if (fifo_cnt_q != '0) begin
            pop         = 1'b1;
            out_valid_d = 1'b1;
            if (head[EntW-1]) begin
              out_data_d = {3'b111, head[4:0]};
              out_last_d = 1'b1;
              state_d    = StIdle;
            end else if (DAT_WIDTH == 8) begin
              out_data_d = {3'b001, head[DAT_WIDTH], head_dat8[3:0]};
              hi_nib_d   = head_dat8[7:4];
              out_last_d = 1'b0;
              state_d    = StEmitLo;
            end else begin
              out_data_d = {3'b000, head[DAT_WIDTH], head_dat8[3:0]};
              out_last_d = 1'b1;
              state_d    = StIdle;
            end
          end else begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
      end
      StEmitLo: begin
        // The high half always follows, whatever cap_en does meanwhile.
        if (out_ready) begin
          out_data_d = {4'b0100, hi_nib_q};
          out_last_d = 1'b1;
          state_d    = StEmitHi;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Buffer storage and pointers
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_ent;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CntW'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CntW'(1);
    end
  end

  // Activity timeout: restart on any CMD/DAT change, drop after the idle window
  always_comb begin
    active_d  = active_q;
    act_cnt_d = act_cnt_q;
    if (pin_chg) begin
      active_d  = 1'b1;
      act_cnt_d = '0;
    end else if (active_q) begin
      if (act_cnt_q == ActLast) begin
        active_d  = 1'b0;
        act_cnt_d = '0;
      end else begin
        act_cnt_d = act_cnt_q + ACT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge FIFO_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      drop_cnt_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_ent_q  <= '0;
      state_q     <= StIdle;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      hi_nib_q    <= '0;
      active_q    <= 1'b0;
      act_cnt_q   <= '0;
    end else begin
      sync_q      <= sync_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      skid_vld_q  <= skid_vld_d;
      skid_ent_q  <= skid_ent_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      hi_nib_q    <= hi_nib_d;
      active_q    <= active_d;
      act_cnt_q   <= act_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign active    = active_q;
  assign overflow  = (drop_cnt_q != 5'd0);

endmodule

// File: tb/tb_mmc_bus_capture.sv
// Bench for mmc_bus_capture: a 4-lane/4-deep instance (A) and an 8-lane/16-deep instance (B)
// watch the same MMC pins; a byte-level model predicts each output stream.
module tb_mmc_bus_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mmc_clk, mmc_cmd, cap_en, cfg_falling;
  logic [7:0] mmc_dat;
  logic       rdy_a_fix, rdy_b_fix, rnd_mode, rnd_a, rnd_b;
  logic       ready_a, ready_b;
  logic [7:0] out_data_a, out_data_b;
  logic       out_valid_a, out_valid_b, active_a, active_b, overflow_a, overflow_b;

  int total = 0;
  int bad = 0;
  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  int  a_occ = 0, a_drops = 0;
  bit  a_stall = 0;
  bit  hold_a = 0, hold_b = 0;
  logic [7:0] hold_da, hold_db;

  always #5 clk = ~clk;

  assign ready_a = rnd_mode ? rnd_a : rdy_a_fix;
  assign ready_b = rnd_mode ? rnd_b : rdy_b_fix;

  mmc_bus_capture #(.DAT_WIDTH(4), .SYNC_STAGES(2), .BUF_DEPTH(4), .ACT_W(6)) dut_a (
    .FIFO_clk(clk), .reset_n(rst_n), .MMC_CLK(mmc_clk), .MMC_CMD(mmc_cmd),
    .MMC_DAT(mmc_dat[3:0]), .cap_en(cap_en), .cfg_falling(cfg_falling),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(ready_a),
    .active(active_a), .overflow(overflow_a)
  );

  mmc_bus_capture #(.DAT_WIDTH(8), .SYNC_STAGES(2), .BUF_DEPTH(16), .ACT_W(6)) dut_b (
    .FIFO_clk(clk), .reset_n(rst_n), .MMC_CLK(mmc_clk), .MMC_CMD(mmc_cmd),
    .MMC_DAT(mmc_dat), .cap_en(cap_en), .cfg_falling(cfg_falling),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(ready_b),
    .active(active_b), .overflow(overflow_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Random ready generator, changes just after the active edge
  always @(posedge clk) begin
    #1;
    rnd_a = ($urandom_range(0, 3) != 0);
    rnd_b = ($urandom_range(0, 3) != 0);
  end

  // Collect transferred bytes and check stall stability, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && out_valid_a && ready_a) got_a.push_back(out_data_a);
    if (rst_n && out_valid_b && ready_b) got_b.push_back(out_data_b);
    if (hold_a && rst_n) check("hold_a", {out_valid_a, out_data_a}, {1'b1, hold_da});
    if (hold_b && rst_n) check("hold_b", {out_valid_b, out_data_b}, {1'b1, hold_db});
    hold_a  = rst_n && out_valid_a && !ready_a;
    hold_b  = rst_n && out_valid_b && !ready_b;
    hold_da = out_data_a;
    hold_db = out_data_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected bytes for one captured (cmd, dat) pair
  task automatic model_push(input logic c, input logic [7:0] d);
    if (cap_en) begin
      exp_b.push_back({3'b001, c, d[3:0]});
      exp_b.push_back({4'b0100, d[7:4]});
      if (a_stall && a_occ >= 4) begin
        a_drops++;
      end else begin
        exp_a.push_back({3'b000, c, d[3:0]});
        a_occ++;
      end
    end
  endtask

  task automatic release_a();
    int n;
    n = (a_drops > 31) ? 31 : a_drops;
    if (a_drops > 0) exp_a.push_back({3'b111, 5'(n)});
    a_drops   = 0;
    a_stall   = 0;
    rdy_a_fix = 1'b1;
  endtask

  // One MMC clock pulse; data is scrambled right after the capture edge
  task automatic pulse(input logic fall, input logic c, input logic [7:0] d);
    cfg_falling = fall;
    model_push(c, d);
    if (!fall) begin
      mmc_cmd = c; mmc_dat = d; tick(2);
      mmc_clk = 1'b1; tick(1);
      mmc_cmd = ~c; mmc_dat = ~d; tick(1);
      mmc_clk = 1'b0; tick(5);
    end else begin
      mmc_clk = 1'b1; tick(1);
      mmc_cmd = c; mmc_dat = d; tick(2);
      mmc_clk = 1'b0; tick(1);
      mmc_cmd = ~c; mmc_dat = ~d; tick(5);
    end
  endtask

  task automatic drain_check(input string tag);
    int guard;
    guard = 0;
    while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && guard < 400) begin
      tick(1);
      guard++;
    end
    tick(12);
    check({tag, "_cnt_a"}, got_a.size(), exp_a.size());
    check({tag, "_cnt_b"}, got_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      check({tag, "_byte_a"}, got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check({tag, "_byte_b"}, got_b[i], exp_b[i]);
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mmc_clk = 0; mmc_cmd = 0; mmc_dat = 8'h00; cap_en = 1; cfg_falling = 0;
    rdy_a_fix = 1; rdy_b_fix = 1; rnd_mode = 0;
    tick(3);
    check("rst_valid_a", out_valid_a, 1'b0);
    check("rst_valid_b", out_valid_b, 1'b0);
    check("rst_data_a", out_data_a, 8'h00);
    check("rst_data_b", out_data_b, 8'h00);
    check("rst_active", {active_a, active_b}, 2'b00);
    check("rst_ovf", {overflow_a, overflow_b}, 2'b00);
    rst_n = 1'b1;
    tick(5);

    // Rising capture, first-byte latency and three 1A bytes on A
    model_push(1'b1, 8'hAA);
    mmc_cmd = 1; mmc_dat = 8'hAA; tick(2);
    mmc_clk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("lat_pre_a", out_valid_a, 1'b0);
    check("lat_pre_b", out_valid_b, 1'b0);
    @(negedge clk);
    check("lat_e2_a", {out_valid_a, out_data_a}, {1'b1, 8'h1A});
    check("lat_e2_b", {out_valid_b, out_data_b}, {1'b1, 8'h3A});
    tick(1);
    mmc_clk = 1'b0; tick(5);
    pulse(1'b0, 1'b1, 8'hAA);
    pulse(1'b0, 1'b1, 8'hAA);
    drain_check("t1");

    // Falling capture: data set while CLK high, scrambled after the falling edge
    pulse(1'b1, 1'b0, 8'h5C);
    pulse(1'b1, 1'b1, 8'h93);
    drain_check("t2");

    // 8-lane pair with a stall between the two halves
    rdy_b_fix = 0;
    pulse(1'b0, 1'b0, 8'hC5);
    check("t3_lo", {out_valid_b, out_data_b}, {1'b1, 8'h25});
    rdy_b_fix = 1; tick(1); rdy_b_fix = 0; tick(3);
    check("t3_hi", {out_valid_b, out_data_b}, {1'b1, 8'h4C});
    rdy_b_fix = 1;
    drain_check("t3");

    // Overflow on the 4-deep instance: 10 edges while stalled
    rdy_a_fix = 0; a_stall = 1; a_occ = 0; a_drops = 0;
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'($urandom), 8'($urandom));
    check("t4_ovf", {overflow_a, overflow_b}, 2'b10);
    release_a();
    tick(3);
    check("t4_ovf_clr", overflow_a, 1'b0);
    pulse(1'b0, 1'b0, 8'h31);
    pulse(1'b0, 1'b1, 8'h4E);
    drain_check("t4");

    // Saturating drop count, marker still sent with capture disabled
    rdy_a_fix = 0; a_stall = 1; a_occ = 0; a_drops = 0;
    for (int i = 0; i < 44; i++) pulse(1'b0, 1'($urandom), 8'($urandom));
    check("t5_ovf", overflow_a, 1'b1);
    cap_en = 0;
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'($urandom), 8'($urandom));
    release_a();
    drain_check("t5");
    check("t5_ovf_clr", overflow_a, 1'b0);
    cap_en = 1;

    // Reset while the high half of a pair is waiting
    rdy_b_fix = 0;
    pulse(1'b0, 1'b1, 8'h7E);
    rdy_b_fix = 1; tick(1); rdy_b_fix = 0; tick(2);
    check("t6_hi", {out_valid_b, out_data_b}, {1'b1, 8'h47});
    rst_n = 1'b0;
    void'(exp_b.pop_back());
    tick(1);
    check("t6_rst_valid", {out_valid_a, out_valid_b}, 2'b00);
    check("t6_rst_data_b", out_data_b, 8'h00);
    check("t6_rst_flags", {active_a, active_b, overflow_a, overflow_b}, 4'b0000);
    rst_n = 1'b1; rdy_b_fix = 1;
    tick(20);
    drain_check("t6_flush");
    pulse(1'b0, 1'b0, 8'h12);
    drain_check("t6_fresh");

    // Activity timeout (2^6-1 idle cycles)
    tick(70);
    check("act_idle", {active_a, active_b}, 2'b00);
    mmc_dat = mmc_dat ^ 8'h01; tick(5);
    check("act_set", {active_a, active_b}, 2'b11);
    tick(70);
    check("act_clr", {active_a, active_b}, 2'b00);
    mmc_dat = mmc_dat ^ 8'h80; tick(5);
    check("act_upper_lane", {active_a, active_b}, 2'b01);
    tick(70);

    // Random edges, modes and back-pressure
    rnd_mode = 1;
    for (int i = 0; i < 30; i++) pulse(1'($urandom), 1'($urandom), 8'($urandom));
    check("rnd_ovf", {overflow_a, overflow_b}, 2'b00);
    rnd_mode = 0;
    drain_check("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
